// File: rtl/axil_pkg.sv
// Shared constants and FSM state encoding for the AXI4-Lite configuration master.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_EXOKAY  = 2'b01;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        RRESP
    } state_t;

endpackage

// File: rtl/axil_cfg_master.sv
// AXI4-Lite master turning single-word read/write commands into one transaction at a time,
// reporting data, response code and a stall warning.
module axil_cfg_master
    import axil_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(C_TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(C_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_WARN = CNT_W'(C_TIMEOUT_CYCLES - 1);

    state_t                          state_q, state_d;
    logic                            cmd_ready_q, cmd_ready_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]               wstrb_q, wstrb_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            bready_q, bready_d;
    logic                            arvalid_q, arvalid_d;
    logic                            rready_q, rready_d;
    logic                            rsp_valid_q, rsp_valid_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                      rsp_resp_q, rsp_resp_d;
    logic [CNT_W-1:0]                tcnt_q, tcnt_d;
    logic                            timeout_q, timeout_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d = cmd_addr;
                    if (cmd_write) begin
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = READ;
                    end
                end
            end
            WRITE: begin
                // AW and W complete independently; B phase starts once both are done.
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (bready_q && M_AXI_BVALID) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = M_AXI_BRESP;
                    state_d     = IDLE;
                end
            end
            READ: begin
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RRESP;
                end
            end
            RRESP: begin
                if (rready_q && M_AXI_RVALID) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_resp_d  = M_AXI_RRESP;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q == IDLE)
            tcnt_d = '0;
        else if (tcnt_q != CNT_MAX)
            tcnt_d = tcnt_q + 1'b1;
        else
            tcnt_d = tcnt_q;

        // tcnt_d counts in-flight cycles already elapsed, so the registered flag
        // rises in the C_TIMEOUT_CYCLES-th in-flight cycle.
        timeout_d   = (state_d != IDLE) && (tcnt_d >= CNT_WARN);
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            tcnt_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            tcnt_q      <= tcnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign timeout       = timeout_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = PROT_DEFAULT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = PROT_DEFAULT;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_cfg_master.sv
// Directed bench for axil_cfg_master with a small configurable AXI4-Lite slave register model.
module tb_axil_cfg_master;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata = '0;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;

    int nvec = 0;
    int nerr = 0;

    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] mem [16];
    logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
    logic [3:0]  wr_strb = '0;

    always #5 clk = ~clk;

    axil_cfg_master #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .C_TIMEOUT_CYCLES(8)
    ) dut (
        .M_AXI_ACLK(clk),       .M_AXI_ARESETN(rstn),
        .cmd_valid(cmd_valid),  .cmd_ready(cmd_ready),  .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),    .cmd_wdata(cmd_wdata),  .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),  .rsp_rdata(rsp_rdata),  .rsp_resp(rsp_resp),
        .timeout(timeout),
        .M_AXI_AWADDR(awaddr),  .M_AXI_AWPROT(awprot),  .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata),    .M_AXI_WSTRB(wstrb),    .M_AXI_WVALID(wvalid),   .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp),    .M_AXI_BVALID(bvalid),  .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr),  .M_AXI_ARPROT(arprot),  .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata),    .M_AXI_RRESP(rresp),    .M_AXI_RVALID(rvalid),   .M_AXI_RREADY(rready)
    );

    // Slave model: READY after a programmable number of VALID cycles; B/R returned as soon as READY is seen.
    always @(negedge clk) begin
        if (!rstn) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        end else begin
            if (awvalid) begin
                awready = (aw_cnt >= aw_delay);
                if (awready) wr_addr = awaddr;
                aw_cnt++;
            end else begin
                awready = 0; aw_cnt = 0;
            end
            if (wvalid) begin
                wready = (w_cnt >= w_delay);
                if (wready) begin wr_data = wdata; wr_strb = wstrb; end
                w_cnt++;
            end else begin
                wready = 0; w_cnt = 0;
            end
            if (arvalid) begin
                arready = (ar_cnt >= ar_delay);
                if (arready) rd_addr = araddr;
                ar_cnt++;
            end else begin
                arready = 0; ar_cnt = 0;
            end
            if (bready) begin
                bvalid = 1; bresp = bresp_cfg;
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) mem[wr_addr[5:2]][b*8 +: 8] = wr_data[b*8 +: 8];
            end else begin
                bvalid = 0;
            end
            if (rready) begin
                rvalid = 1; rdata = mem[rd_addr[5:2]]; rresp = rresp_cfg;
            end else begin
                rvalid = 0;
            end
        end
    end

    // Starts at a negedge with cmd_ready high; returns at the negedge of the rsp_valid cycle.
    task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output logic [1:0] rr, output int lat);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(negedge clk);
        cmd_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        rr = rsp_resp;
    endtask

    task automatic test_reset;
        logic [15:0] outs;
        repeat (3) @(negedge clk);
        outs = {awvalid, wvalid, bready, arvalid, rready, cmd_ready, rsp_valid, timeout,
                rsp_resp, |awaddr, |araddr, |wdata, |wstrb, |rsp_rdata, |awprot | |arprot};
        nvec++;
        if (outs !== 16'h0) begin
            nerr++; $display("FAIL reset_outputs: got %h expected 0000", outs);
        end
        rstn = 1;
        @(negedge clk);
        nvec++;
        if (cmd_ready !== 1'b1) begin
            nerr++; $display("FAIL reset_release_cmd_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_write_basic;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0; cmd_wdata = 32'h0101FFFF; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 0;
        nvec++;
        if ({awvalid, wvalid, bready} !== 3'b110 || awaddr !== 32'h0 || wdata !== 32'h0101FFFF || wstrb !== 4'hF) begin
            nerr++; $display("FAIL wr_cycle1: aw/w/b=%b addr=%h data=%h strb=%h expected 110 0 0101ffff f",
                             {awvalid, wvalid, bready}, awaddr, wdata, wstrb);
        end
        @(negedge clk);
        nvec++;
        if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin
            nerr++; $display("FAIL wr_cycle2: aw/w/b/rsp=%b expected 0010", {awvalid, wvalid, bready, rsp_valid});
        end
        @(negedge clk);
        nvec++;
        if ({rsp_valid, cmd_ready, bready, timeout} !== 4'b1100 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
            nerr++; $display("FAIL wr_cycle3: rsp/rdy/b/to=%b resp=%b rdata=%h expected 1100 00 0",
                             {rsp_valid, cmd_ready, bready, timeout}, rsp_resp, rsp_rdata);
        end
        @(negedge clk);
        nvec++;
        if (rsp_valid !== 1'b0) begin
            nerr++; $display("FAIL wr_cycle4_rsp_pulse: got %b expected 0", rsp_valid);
        end
    endtask

    task automatic test_aw_delay;
        logic [4:0] got, exp;
        logic [31:0] rd;
        logic [1:0]  rr;
        int lat;
        aw_delay = 4;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h14; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            cmd_valid = 0;
            got = {awvalid, wvalid, bready, rsp_valid, timeout};
            exp = {k <= 5, k == 1, k == 6, k == 7, 1'b0};
            nvec++;
            if (got !== exp) begin
                nerr++; $display("FAIL aw_delay_cycle%0d: aw/w/b/rsp/to=%b expected %b", k, got, exp);
            end
        end
        aw_delay = 0;
        w_delay = 2;
        do_cmd(1'b1, 32'h18, 32'h0BAD_F00D, 4'hF, rd, rr, lat);
        nvec++;
        if (lat !== 5 || rr !== 2'b00) begin
            nerr++; $display("FAIL w_delay_latency: lat=%0d resp=%b expected 5 00", lat, rr);
        end
        w_delay = 0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        logic [31:0] rd;
        logic [1:0]  rr;
        int lat;
        addrs = '{32'h4, 32'h8, 32'hC};
        datas = '{32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 3; i++) begin
                nvec++;
                if (cmd_ready !== 1'b1) begin
                    nerr++; $display("FAIL b2b_ready_p%0d_%0d: got %b expected 1", pass, i, cmd_ready);
                end
                do_cmd(pass == 0, addrs[i], datas[i], 4'hF, rd, rr, lat);
                nvec++;
                if (lat !== 3 || rr !== 2'b00 || rd !== ((pass == 0) ? 32'h0 : datas[i])) begin
                    nerr++; $display("FAIL b2b_p%0d_%0d: lat=%0d resp=%b rdata=%h expected 3 00 %h",
                                     pass, i, lat, rr, rd, (pass == 0) ? 32'h0 : datas[i]);
                end
            end
        end
    endtask

    task automatic test_err_resp;
        logic [31:0] rd;
        logic [1:0]  rr;
        int lat;
        rresp_cfg = 2'b10;
        do_cmd(1'b0, 32'h8, 32'h0, 4'h0, rd, rr, lat);
        nvec++;
        if (rr !== 2'b10 || rd !== 32'hDEAD0011 || lat !== 3) begin
            nerr++; $display("FAIL rd_slverr: resp=%b rdata=%h lat=%0d expected 10 dead0011 3", rr, rd, lat);
        end
        rresp_cfg = 2'b00;
        bresp_cfg = 2'b11;
        do_cmd(1'b1, 32'h1C, 32'h55AA55AA, 4'hF, rd, rr, lat);
        nvec++;
        if (rr !== 2'b11 || rd !== 32'h0) begin
            nerr++; $display("FAIL wr_decerr: resp=%b rdata=%h expected 11 0", rr, rd);
        end
        bresp_cfg = 2'b00;
    endtask

    task automatic test_timeout;
        logic [3:0] got, exp;
        ar_delay = 20;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h4;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            cmd_valid = 0;
            got = {arvalid, rready, rsp_valid, timeout};
            exp = {k <= 21, k == 22, k == 23, k >= 8 && k <= 22};
            nvec++;
            if (got !== exp) begin
                nerr++; $display("FAIL timeout_cycle%0d: ar/r/rsp/to=%b expected %b", k, got, exp);
            end
            if (k == 23) begin
                nvec++;
                if (rsp_rdata !== 32'hABCD0001 || rsp_resp !== 2'b00) begin
                    nerr++; $display("FAIL timeout_completion: rdata=%h resp=%b expected abcd0001 00", rsp_rdata, rsp_resp);
                end
            end
        end
        ar_delay = 0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic [1:0]  rr;
        int lat;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'hCAFE0000; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        nvec++;
        if (bready !== 1'b1) begin
            nerr++; $display("FAIL rst_mid_in_wresp: bready=%b expected 1", bready);
        end
        rstn = 0;
        @(negedge clk);
        nvec++;
        if ({awvalid, wvalid, bready, arvalid, rready, cmd_ready, rsp_valid, timeout} !== 8'h0) begin
            nerr++; $display("FAIL rst_mid_outputs: got %b expected 00000000",
                             {awvalid, wvalid, bready, arvalid, rready, cmd_ready, rsp_valid, timeout});
        end
        rstn = 1;
        @(negedge clk);
        nvec++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            nerr++; $display("FAIL rst_mid_release: rdy/rsp=%b expected 10", {cmd_ready, rsp_valid});
        end
        @(negedge clk);
        nvec++;
        if (rsp_valid !== 1'b0) begin
            nerr++; $display("FAIL rst_mid_no_rsp: got %b expected 0", rsp_valid);
        end
        do_cmd(1'b0, 32'hC, 32'h0, 4'h0, rd, rr, lat);
        nvec++;
        if (rd !== 32'hBEEF0011 || rr !== 2'b00 || lat !== 3) begin
            nerr++; $display("FAIL rst_mid_recover: rdata=%h resp=%b lat=%0d expected beef0011 00 3", rd, rr, lat);
        end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = '0;
        test_reset();
        test_write_basic();
        test_aw_delay();
        test_back_to_back();
        test_err_resp();
        test_timeout();
        test_reset_mid();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
